axi_burst_mem_slave: RTL

- AXI4 (INCR-only) slave memory responder; final stage of the chip AXI chain, directly downstream of the passthrough VIP.
- Consumes the master's write and read bursts, stores data in an on-chip single-port RAM, returns B/R responses.
- Serves as a real memory target for CNN weight/feature-map traffic in place of a VIP slave model.

---
 rtl/axi_burst_mem_pkg.sv | 19 +
 rtl/axi_mem_sp_ram.sv | 29 ++
 rtl/axi_burst_mem_slave.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_mem_pkg.sv
// Shared types and constants for the AXI burst memory slave.
package axi_burst_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StWrData,
    StWrResp,
    StRdAddr,
    StRdData
  } mem_state_t;

  function automatic int unsigned bytes_log2(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi_mem_sp_ram.sv
// Single-port synchronous RAM with byte write enables and 1-cycle read latency.
module axi_mem_sp_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [WIDTH/8-1:0]       be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < WIDTH / 8; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 INCR-only slave backed by single-port RAM, one burst in flight at a time.
// Define AXI_BURST_MEM_STATS_EN to add burst/error counter outputs.
module axi_burst_mem_slave
  import axi_burst_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
`ifdef AXI_BURST_MEM_STATS_EN
  ,
  output logic [31:0]             wr_burst_cnt,
  output logic [31:0]             rd_burst_cnt,
  output logic [15:0]             err_cnt
`endif
);

  localparam int unsigned BL  = bytes_log2(DATA_WIDTH);
  localparam int unsigned WA  = ADDR_WIDTH - BL;
  localparam int unsigned RAW = $clog2(MEM_DEPTH);

  mem_state_t          state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [WA-1:0]       addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          beat_q, beat_d;
  logic                err_q, err_d;
  logic                rd_oor_q, rd_oor_d;
  logic                prefer_rd_q, prefer_rd_d;
  logic                awready_q, awready_d;
  logic                arready_q, arready_d;

  logic                  in_range;
  logic                  last_beat;
  logic                  ram_en, ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Sub-word address bits carry no meaning for an aligned word memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[BL-1:0], araddr[BL-1:0]};

  assign in_range  = 32'(addr_q) < MEM_DEPTH;
  assign last_beat = (beat_q == len_q);

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    err_d       = err_q;
    rd_oor_d    = rd_oor_q;
    prefer_rd_d = prefer_rd_q;
    awready_d   = 1'b0;
    arready_d   = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (awvalid && (!arvalid || !prefer_rd_q)) begin
          awready_d   = 1'b1;
          id_d        = awid;
          addr_d      = awaddr[ADDR_WIDTH-1:BL];
          len_d       = awlen;
          beat_d      = '0;
          err_d       = 1'b0;
          prefer_rd_d = 1'b1;
          state_d     = StWrData;
        end else if (arvalid) begin
          arready_d   = 1'b1;
          id_d        = arid;
          addr_d      = araddr[ADDR_WIDTH-1:BL];
          len_d       = arlen;
          beat_d      = '0;
          prefer_rd_d = 1'b0;
          state_d     = StRdAddr;
        end
      end
      StWrData: begin
        if (wvalid) begin
          ram_en = in_range;
          ram_we = in_range;
          // Beat count is authoritative; a disagreeing wlast only flags an error.
          if (!in_range || (wlast != last_beat)) err_d = 1'b1;
          if (last_beat) begin
            state_d = StWrResp;
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = addr_q + 1'b1;
          end
        end
      end
      StWrResp: begin
        if (bready) state_d = StIdle;
      end
      StRdAddr: begin
        ram_en   = in_range;
        rd_oor_d = !in_range;
        state_d  = StRdData;
      end
      StRdData: begin
        if (rready) begin
          if (last_beat) begin
            state_d = StIdle;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = addr_q + 1'b1;
            state_d = StRdAddr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= StIdle;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      rd_oor_q    <= 1'b0;
      prefer_rd_q <= 1'b0;
      awready_q   <= 1'b0;
      arready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      rd_oor_q    <= rd_oor_d;
      prefer_rd_q <= prefer_rd_d;
      awready_q   <= awready_d;
      arready_q   <= arready_d;
    end
  end

  always_comb begin
    awready = awready_q;
    arready = arready_q;
    wready  = (state_q == StWrData);
    bvalid  = (state_q == StWrResp);
    bid     = bvalid ? id_q : '0;
    bresp   = (bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
    rvalid  = (state_q == StRdData);
    rid     = rvalid ? id_q : '0;
    rlast   = rvalid && last_beat;
    rresp   = (rvalid && rd_oor_q) ? RESP_SLVERR : RESP_OKAY;
    // RAM output register is not reset, so gate it by state.
    rdata   = (rvalid && !rd_oor_q) ? ram_rdata : '0;
  end

  axi_mem_sp_ram #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (aclk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (wstrb),
    .addr  (addr_q[RAW-1:0]),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

`ifdef AXI_BURST_MEM_STATS_EN
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_burst_cnt <= '0;
      rd_burst_cnt <= '0;
      err_cnt      <= '0;
    end else begin
      if (bvalid && bready && (wr_burst_cnt != '1)) wr_burst_cnt <= wr_burst_cnt + 32'd1;
      if (rvalid && rready && rlast && (rd_burst_cnt != '1)) begin
        rd_burst_cnt <= rd_burst_cnt + 32'd1;
      end
      if (((bvalid && bready && (bresp == RESP_SLVERR)) ||
           (rvalid && rready && (rresp == RESP_SLVERR))) && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
